// File: rtl/rv_timer_reg_pkg.sv
// Shared constants for the rv_timer register stage: word addresses, field widths
// and reset values.
package rv_timer_reg_pkg;

    localparam int unsigned ADDR_W = 6;

    localparam logic [ADDR_W-1:0] ADDR_CTRL          = 6'h00;
    localparam logic [ADDR_W-1:0] ADDR_CFG           = 6'h01;
    localparam logic [ADDR_W-1:0] ADDR_INTR_ENABLE   = 6'h02;
    localparam logic [ADDR_W-1:0] ADDR_INTR_STATE    = 6'h03;
    localparam logic [ADDR_W-1:0] ADDR_INTR_TEST     = 6'h04;
    localparam logic [ADDR_W-1:0] ADDR_MTIME_LO      = 6'h05;
    localparam logic [ADDR_W-1:0] ADDR_MTIME_HI      = 6'h06;
    localparam logic [ADDR_W-1:0] ADDR_MTIMECMP_BASE = 6'h08;

    localparam int unsigned PRESCALER_W = 12;
    localparam int unsigned STEP_W      = 8;

    localparam logic [PRESCALER_W-1:0] PRESCALER_RST = '0;
    localparam logic [STEP_W-1:0]      STEP_RST      = 8'd1;
    localparam logic [63:0]            MTIMECMP_RST  = '1;

endpackage

// File: rtl/rv_timer_intr_state.sv
// One interrupt bit: sticky state (hardware set, test set, W1C clear with set
// priority) plus its enable, producing the masked interrupt line.
module rv_timer_intr_state (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic hw_set_i,
    input  logic test_set_i,
    input  logic clr_i,
    input  logic en_we_i,
    input  logic en_wdata_i,
    output logic state_o,
    output logic enable_o,
    output logic intr_o
);

    logic r_state;
    logic r_enable;
    logic w_state_d;

    // Set sources override a same-cycle clear, so the bit re-arms while the compare holds.
    always_comb begin
        w_state_d = (r_state & ~clr_i) | hw_set_i | test_set_i;
    end

    // State and enable registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= 1'b0;
            r_enable <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (en_we_i) begin
                r_enable <= en_wdata_i;
            end
        end
    end

    assign state_o  = r_state;
    assign enable_o = r_enable;
    assign intr_o   = r_state & r_enable;

endmodule

// File: rtl/rv_timer_regs.sv
// Register/state stage around the timer core: mtime, mtimecmp[N], control and
// interrupt registers behind a 32-bit word register port.
// Optional: define RV_TIMER_HI_SNAPSHOT_EN to latch mtime[63:32] on a MTIME_LO
// read and return that snapshot on the following MTIME_HI read.
module rv_timer_regs
    import rv_timer_reg_pkg::*;
#(
    parameter int unsigned N = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_i,
    input  logic                   we_i,
    input  logic [5:0]             addr_i,
    input  logic [31:0]            wdata_i,
    output logic                   rvalid_o,
    output logic [31:0]            rdata_o,
    output logic                   rerror_o,
    output logic                   active_o,
    output logic [PRESCALER_W-1:0] prescaler_o,
    output logic [STEP_W-1:0]      step_o,
    output logic [63:0]            mtime_o,
    output logic [63:0]            mtimecmp_o [N],
    input  logic                   tick_i,
    input  logic [63:0]            mtime_d_i,
    input  logic [N-1:0]           intr_i,
    output logic [N-1:0]           intr_o
);

    logic                   r_active;
    logic [PRESCALER_W-1:0] r_prescaler;
    logic [STEP_W-1:0]      r_step;
    logic [63:0]            r_mtime;
    logic [63:0]            r_mtimecmp [N];
    logic                   r_rvalid;
    logic [31:0]            r_rdata;
    logic                   r_rerror;

    logic        w_rd;
    logic        w_wr;
    logic [4:0]  w_cmp_idx;
    logic        w_cmp_sel;
    logic        w_hit;
    logic [31:0] w_rdata;
    logic [31:0] w_mtime_hi_rd;
    logic [63:0] w_mtime_d;
    logic        w_wr_ctrl;
    logic        w_wr_cfg;
    logic        w_wr_intr_enable;
    logic        w_wr_intr_state;
    logic        w_wr_intr_test;
    logic        w_wr_mtime_lo;
    logic        w_wr_mtime_hi;
    logic [N-1:0] w_cmp_we_lo;
    logic [N-1:0] w_cmp_we_hi;
    logic [N-1:0] w_intr_state;
    logic [N-1:0] w_intr_enable;

    assign w_rd = req_i & ~we_i;
    assign w_wr = req_i & we_i;

    // Comparator decode: addresses from the base pair up as LO/HI per hart.
    always_comb begin
        w_cmp_idx = 5'((addr_i - ADDR_MTIMECMP_BASE) >> 1);
        w_cmp_sel = (addr_i >= ADDR_MTIMECMP_BASE) && ({27'd0, w_cmp_idx} < N);
    end

    // Read mux and address-hit detection; unmapped addresses read 0.
    always_comb begin
        w_rdata = '0;
        w_hit   = 1'b1;
        case (addr_i)
            ADDR_CTRL:        w_rdata[0] = r_active;
            ADDR_CFG: begin
                w_rdata[PRESCALER_W-1:0] = r_prescaler;
                w_rdata[23:16]           = r_step;
            end
            ADDR_INTR_ENABLE: w_rdata[N-1:0] = w_intr_enable;
            ADDR_INTR_STATE:  w_rdata[N-1:0] = w_intr_state;
            ADDR_INTR_TEST:   w_rdata = '0;
            ADDR_MTIME_LO:    w_rdata = r_mtime[31:0];
            ADDR_MTIME_HI:    w_rdata = w_mtime_hi_rd;
            default: begin
                if (w_cmp_sel) begin
                    for (int unsigned t = 0; t < N; t++) begin
                        if (w_cmp_idx == 5'(t)) begin
                            w_rdata = addr_i[0] ? r_mtimecmp[t][63:32] : r_mtimecmp[t][31:0];
                        end
                    end
                end else begin
                    w_hit = 1'b0;
                end
            end
        endcase
    end

    // Per-register write strobes.
    always_comb begin
        w_wr_ctrl        = w_wr && (addr_i == ADDR_CTRL);
        w_wr_cfg         = w_wr && (addr_i == ADDR_CFG);
        w_wr_intr_enable = w_wr && (addr_i == ADDR_INTR_ENABLE);
        w_wr_intr_state  = w_wr && (addr_i == ADDR_INTR_STATE);
        w_wr_intr_test   = w_wr && (addr_i == ADDR_INTR_TEST);
        w_wr_mtime_lo    = w_wr && (addr_i == ADDR_MTIME_LO);
        w_wr_mtime_hi    = w_wr && (addr_i == ADDR_MTIME_HI);
        w_cmp_we_lo      = '0;
        w_cmp_we_hi      = '0;
        for (int unsigned t = 0; t < N; t++) begin
            if (w_wr && w_cmp_sel && (w_cmp_idx == 5'(t))) begin
                w_cmp_we_lo[t] = ~addr_i[0];
                w_cmp_we_hi[t] = addr_i[0];
            end
        end
    end

    // Next mtime: a software write to either half wins over the core's tick.
    always_comb begin
        w_mtime_d = r_mtime;
        if (w_wr_mtime_lo) begin
            w_mtime_d[31:0] = wdata_i;
        end else if (w_wr_mtime_hi) begin
            w_mtime_d[63:32] = wdata_i;
        end else if (tick_i) begin
            w_mtime_d = mtime_d_i;
        end
    end

    // Control, config and mtime registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_active    <= 1'b0;
            r_prescaler <= PRESCALER_RST;
            r_step      <= STEP_RST;
            r_mtime     <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_active <= wdata_i[0];
            end
            if (w_wr_cfg) begin
                r_prescaler <= wdata_i[PRESCALER_W-1:0];
                r_step      <= wdata_i[23:16];
            end
            r_mtime <= w_mtime_d;
        end
    end

    // Comparator registers, written one 32-bit half at a time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned t = 0; t < N; t++) begin
                r_mtimecmp[t] <= MTIMECMP_RST;
            end
        end else begin
            for (int unsigned t = 0; t < N; t++) begin
                if (w_cmp_we_lo[t]) begin
                    r_mtimecmp[t][31:0] <= wdata_i;
                end
                if (w_cmp_we_hi[t]) begin
                    r_mtimecmp[t][63:32] <= wdata_i;
                end
            end
        end
    end

    // Registered response, one cycle after every request; write responses carry 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rerror <= 1'b0;
        end else begin
            r_rvalid <= req_i;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
            r_rerror <= req_i & ~w_hit;
        end
    end

`ifdef RV_TIMER_HI_SNAPSHOT_EN
    logic [31:0] r_mtime_hi_shadow;

    // Capture the upper half alongside a LO read so LO-then-HI is carry-consistent.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mtime_hi_shadow <= '0;
        end else if (w_rd && (addr_i == ADDR_MTIME_LO)) begin
            r_mtime_hi_shadow <= r_mtime[63:32];
        end
    end

    assign w_mtime_hi_rd = r_mtime_hi_shadow;
`else
    assign w_mtime_hi_rd = r_mtime[63:32];
`endif

    for (genvar t = 0; t < N; t++) begin : g_intr
        rv_timer_intr_state u_intr_state (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .hw_set_i   (intr_i[t]),
            .test_set_i (w_wr_intr_test & wdata_i[t]),
            .clr_i      (w_wr_intr_state & wdata_i[t]),
            .en_we_i    (w_wr_intr_enable),
            .en_wdata_i (wdata_i[t]),
            .state_o    (w_intr_state[t]),
            .enable_o   (w_intr_enable[t]),
            .intr_o     (intr_o[t])
        );
    end

    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign rerror_o    = r_rerror;
    assign active_o    = r_active;
    assign prescaler_o = r_prescaler;
    assign step_o      = r_step;
    assign mtime_o     = r_mtime;
    assign mtimecmp_o  = r_mtimecmp;

endmodule

// File: doc/rv_timer_regs.md
Name: rv_timer_regs

Overview:
- Register/state stage directly around the timer core: holds mtime, mtimecmp[N], control and interrupt registers.
- Feeds the core its active/prescaler/step/mtime/mtimecmp inputs.
- Consumes the core's tick, mtime_d and raw intr.
- Exposes a simple 32-bit word register port to the bus adapter and interrupt lines to the PLIC.

Parameters:
- N, 1, number of harts/comparators (1..8).

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  register access request, single-cycle
- we_i  input  1  1 = write, 0 = read
- addr_i  input  6  word address
- wdata_i  input  32  write data
- rvalid_o  output  1  response valid, one cycle after req_i
- rdata_o  output  32  read data, valid with rvalid_o
- rerror_o  output  1  unmapped address, valid with rvalid_o
- active_o  output  1  to core
- prescaler_o  output  12  to core
- step_o  output  8  to core
- mtime_o  output  64  to core
- mtimecmp_o  output  64 x N (unpacked [N])  to core
- tick_i  input  1  from core
- mtime_d_i  input  64  from core, mtime + step
- intr_i  input  N  raw compare result from core
- intr_o  output  N  to PLIC

Behaviour:
Register map (word address):
- 0x00 CTRL: bit0 active.
- 0x01 CFG: [11:0] prescaler, [23:16] step.
- 0x02 INTR_ENABLE: [N-1:0].
- 0x03 INTR_STATE: [N-1:0], write-1-to-clear.
- 0x04 INTR_TEST: write-only; writing 1 sets state; reads 0.
- 0x05 MTIME_LO, 0x06 MTIME_HI.
- 0x08+2t MTIMECMP_LO[t], 0x09+2t MTIMECMP_HI[t].
- Any other address, and any mtimecmp address with t>=N: rerror_o=1. Writes are dropped; reads return 0.

Reset values:
- active 0, prescaler 0, step 1, intr_enable 0, intr_state 0, mtime 0.
- mtimecmp[t] all-ones, so no interrupt fires out of reset.
- rvalid_o 0, rdata_o 0, rerror_o 0, intr_o 0.

Access timing:
- rvalid_o/rdata_o/rerror_o are registered: asserted exactly one cycle after a req_i cycle, for one cycle. Writes also produce a response.
- Write effects are visible on outputs the cycle after the write.
- Unused field bits read 0.

mtime update:
- tick_i=1 → mtime <= mtime_d_i.
- A software write to MTIME_LO/HI in the same cycle wins: the written half takes wdata_i, the other half keeps its old value, and that tick's increment is dropped.

Interrupt state:
- intr_state[t] sets when intr_i[t]=1 (sampled every cycle) or on INTR_TEST bit t.
- Cleared by a W1C write to INTR_STATE.
- Set beats clear in the same cycle. Consequence: the state re-sets while mtime >= mtimecmp remains true.
- intr_o = intr_state & intr_enable, combinational from registers (no extra latency).
- active=0 does not clear intr_state.

Reset mid-operation: all registers return to reset values asynchronously. A pending read response is discarded.

Optional Feature:
- Macro: RV_TIMER_HI_SNAPSHOT_EN.
- Enabled:
  - A read of MTIME_LO captures mtime[63:32] into a 32-bit shadow register (reset 0) in the same cycle.
  - A read of MTIME_HI returns the shadow.
  - Gives a carry-consistent 64-bit read in LO-then-HI order.
- Disabled: MTIME_HI reads return live mtime[63:32]; no shadow register exists.

Decomposition:
- Package rv_timer_reg_pkg:
  - address localparams (ADDR_CTRL .. ADDR_MTIMECMP_BASE);
  - field width constants (PRESCALER_W=12, STEP_W=8);
  - reset constants (STEP_RST=8'd1, MTIMECMP_RST all-ones).
- One sub-module: rv_timer_intr_state, a per-bit set/W1C/test/enable cell, generated N times.

Test Plan:
- Reset, then read 0x08/0x09 → 0xFFFF_FFFF both; read 0x01 → 0x0001_0000; intr_o=0.
- Write CFG=0x0002_0003, CTRL=1; drive tick_i on one cycle with mtime_d_i=0x2 → MTIME_LO reads 0x2. Same cycle: tick_i=1 and MTIME_LO write 0x100 → MTIME_LO=0x100.
- MTIMECMP[0]=0x10, intr_i[0] pulsed 1 cycle, INTR_ENABLE=0 → INTR_STATE=1, intr_o=0. Write ENABLE=1 → intr_o[0]=1. W1C with intr_i low → cleared. W1C with intr_i high in the same cycle → stays 1.
- Write INTR_TEST=1 with intr_i=0 → INTR_STATE[0]=1 next cycle; INTR_TEST reads 0.
- With macro: mtime=0x0000_0001_FFFF_FFFF, read LO; next cycle tick to 0x2_0000_0000; read HI → 0x1. Without macro → 0x2.
- Read address 0x3F, or 0x0A with N=1 → rvalid_o=1, rerror_o=1, rdata_o=0; no register changes.
